// File: rtl/uart_pkg.sv
// Shared state encodings and line-level constants for the UART serial link.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    localparam logic FRAME_START = 1'b0;
    localparam logic FRAME_STOP  = 1'b1;
    localparam logic LINE_IDLE   = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Baud counter for one UART direction: counts while run is high, wraps every CLKS_PER_BIT
// cycles (tick on the last cycle) and flags an extra in-bit position given by MARK.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int MARK         = CLKS_PER_BIT / 2 - 1
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic restart,
    output logic tick,
    output logic mark_tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MARK_C = CW'(MARK);

    logic [CW-1:0] count;

    // Held at zero while idle so the first cycle of a bit always starts at count 0.
    always_ff @(posedge clk) begin
        if (reset || restart || !run) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick      = run && (count == LAST);
    assign mark_tick = run && (count == MARK_C);

endmodule

// File: rtl/uart_serial_link.sv
// Serial line stage between the processor PIOs and the RS-232 pins: 8N1 (or 8E1 when
// UART_PARITY_EN is defined) transmitter with a double-buffered holding register, and receiver.
module uart_serial_link
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_load,
    input  logic                 tx_enable,
    output logic                 tx_char_sent,
    output logic                 tx_serial,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_char_received,
    output logic                 rx_frame_error
);

    localparam int IDXW = $clog2(DATA_BITS + 1);
    localparam logic [IDXW-1:0] LAST_BIT = IDXW'(DATA_BITS - 1);

    // ------------------------------------------------------------------ TX
    tx_state_t             tx_state;
    logic [DATA_BITS-1:0]  tx_hold;
    logic [DATA_BITS-1:0]  tx_shift;
    logic                  tx_pending;
    logic [IDXW-1:0]       tx_bit_idx;
    logic                  tx_tick;
    logic                  tx_mark;
    logic                  tx_run;
    logic                  tx_start_frame;
`ifdef UART_PARITY_EN
    logic                  tx_parity;
`endif

    assign tx_run = (tx_state != TX_IDLE);

    // A new frame may begin from idle or straight out of the last stop-bit cycle.
    assign tx_start_frame = tx_pending && tx_enable &&
                            ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_tick));

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .MARK         (CLKS_PER_BIT - 2)
    ) u_tx_timer (
        .clk       (clk),
        .reset     (reset),
        .run       (tx_run),
        .restart   (1'b0),
        .tick      (tx_tick),
        .mark_tick (tx_mark)
    );

    // A load in the same cycle a frame starts keeps the new byte pending behind it.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_hold    <= '0;
            tx_pending <= 1'b0;
        end else if (tx_load) begin
            tx_hold    <= tx_data;
            tx_pending <= 1'b1;
        end else if (tx_start_frame) begin
            tx_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state     <= TX_IDLE;
            tx_serial    <= LINE_IDLE;
            tx_char_sent <= 1'b0;
            tx_shift     <= '0;
            tx_bit_idx   <= '0;
`ifdef UART_PARITY_EN
            tx_parity    <= 1'b0;
`endif
        end else begin
            tx_char_sent <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (tx_start_frame) begin
                        tx_state  <= TX_START;
                        tx_serial <= FRAME_START;
                        tx_shift  <= tx_hold;
`ifdef UART_PARITY_EN
                        tx_parity <= ^tx_hold;
`endif
                    end
                end
                TX_START: begin
                    if (tx_tick) begin
                        tx_state   <= TX_DATA;
                        tx_serial  <= tx_shift[0];
                        tx_shift   <= tx_shift >> 1;
                        tx_bit_idx <= '0;
                    end
                end
                TX_DATA: begin
                    if (tx_tick) begin
                        if (tx_bit_idx == LAST_BIT) begin
`ifdef UART_PARITY_EN
                            tx_state  <= TX_PARITY;
                            tx_serial <= tx_parity;
`else
                            tx_state  <= TX_STOP;
                            tx_serial <= FRAME_STOP;
`endif
                        end else begin
                            tx_serial  <= tx_shift[0];
                            tx_shift   <= tx_shift >> 1;
                            tx_bit_idx <= tx_bit_idx + IDXW'(1);
                        end
                    end
                end
`ifdef UART_PARITY_EN
                TX_PARITY: begin
                    if (tx_tick) begin
                        tx_state  <= TX_STOP;
                        tx_serial <= FRAME_STOP;
                    end
                end
`endif
                TX_STOP: begin
                    // Set one cycle early so the pulse lands on the final stop cycle.
                    if (tx_mark) begin
                        tx_char_sent <= 1'b1;
                    end
                    if (tx_tick) begin
                        if (tx_start_frame) begin
                            tx_state  <= TX_START;
                            tx_serial <= FRAME_START;
                            tx_shift  <= tx_hold;
`ifdef UART_PARITY_EN
                            tx_parity <= ^tx_hold;
`endif
                        end else begin
                            tx_state  <= TX_IDLE;
                            tx_serial <= LINE_IDLE;
                        end
                    end
                end
                default: begin
                    tx_state  <= TX_IDLE;
                    tx_serial <= LINE_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------ RX
    rx_state_t             rx_state;
    logic                  rx_meta;
    logic                  rx_sync;
    logic [DATA_BITS-1:0]  rx_shift;
    logic [IDXW-1:0]       rx_bit_idx;
    logic                  rx_tick;
    logic                  rx_mark;
    logic                  rx_run;
    logic                  rx_restart;
`ifdef UART_PARITY_EN
    logic                  rx_parity_ok;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= LINE_IDLE;
            rx_sync <= LINE_IDLE;
        end else begin
            rx_meta <= rx_serial;
            rx_sync <= rx_meta;
        end
    end

    assign rx_run     = (rx_state != RX_IDLE) && (rx_state != RX_WAIT_HIGH);
    // Re-phase the counter at the start-bit centre so later ticks fall on bit centres.
    assign rx_restart = (rx_state == RX_START) && rx_mark;

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .MARK         (CLKS_PER_BIT / 2 - 1)
    ) u_rx_timer (
        .clk       (clk),
        .reset     (reset),
        .run       (rx_run),
        .restart   (rx_restart),
        .tick      (rx_tick),
        .mark_tick (rx_mark)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state         <= RX_IDLE;
            rx_data          <= '0;
            rx_char_received <= 1'b0;
            rx_frame_error   <= 1'b0;
            rx_shift         <= '0;
            rx_bit_idx       <= '0;
`ifdef UART_PARITY_EN
            rx_parity_ok     <= 1'b0;
`endif
        end else begin
            rx_char_received <= 1'b0;
            rx_frame_error   <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_sync == FRAME_START) begin
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_mark) begin
                        if (rx_sync != FRAME_START) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_state   <= RX_DATA;
                            rx_bit_idx <= '0;
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                        if (rx_bit_idx == LAST_BIT) begin
`ifdef UART_PARITY_EN
                            rx_state <= RX_PARITY;
`else
                            rx_state <= RX_STOP;
`endif
                        end else begin
                            rx_bit_idx <= rx_bit_idx + IDXW'(1);
                        end
                    end
                end
`ifdef UART_PARITY_EN
                RX_PARITY: begin
                    if (rx_tick) begin
                        rx_parity_ok <= (rx_sync == ^rx_shift);
                        rx_state     <= RX_STOP;
                    end
                end
`endif
                RX_STOP: begin
                    if (rx_tick) begin
                        if (rx_sync == FRAME_STOP) begin
`ifdef UART_PARITY_EN
                            if (rx_parity_ok) begin
                                rx_data          <= rx_shift;
                                rx_char_received <= 1'b1;
                            end else begin
                                rx_frame_error   <= 1'b1;
                            end
`else
                            rx_data          <= rx_shift;
                            rx_char_received <= 1'b1;
`endif
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_frame_error <= 1'b1;
                            rx_state       <= RX_WAIT_HIGH;
                        end
                    end
                end
                // A line stuck low after a bad stop bit must not look like a new start.
                RX_WAIT_HIGH: begin
                    if (rx_sync == LINE_IDLE) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: begin
                    rx_state <= RX_IDLE;
                end
            endcase
        end
    end

endmodule
